// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, bit indices and FSM states.
package csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MEIE     = 11;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIP_MEIP     = 11;
    localparam int unsigned MIP_MTIP     = 7;

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } csr_state_e;

endpackage

// File: rtl/inf_EX_CSR.sv
// EX-stage <-> CSR-unit handshake bundle.
interface inf_EX_CSR;
    logic [31:0] pc;
    logic [11:0] csr_addr;
    logic [31:0] rs1_rdata;
    logic        reg_wr;
    logic        wr;
    logic        set;
    logic        clr;
    logic        mret;
    logic        wfi;
    logic [31:0] rd_wdata;

    modport CSR2EX (
        input  pc, csr_addr, rs1_rdata, reg_wr, wr, set, clr, mret, wfi,
        output rd_wdata
    );

    modport EX2CSR (
        output pc, csr_addr, rs1_rdata, reg_wr, wr, set, clr, mret, wfi,
        input  rd_wdata
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independent 32-bit half write ports.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] value
);

    logic [63:0] value_inc;

    assign value_inc = value + {63'd0, inc_en};

    // A half write freezes the other half: no increment, no carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (wr_lo) begin
            value[31:0] <= wr_data;
        end else if (wr_hi) begin
            value[63:32] <= wr_data;
        end else begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file, counters and trap/WFI controller sitting behind the EX stage.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    inf_EX_CSR.CSR2EX         ex2csr,
    input  logic              ex_valid_i,
    input  logic              exemem_en_i,
    input  logic              retire_i,
    input  logic              meip_i,
    input  logic              mtip_i,
    output logic              redirect_o,
    output logic [31:0]       redirect_pc_o,
    output logic              wfi_stall_o
);

    csr_state_e  state_q, state_d;
    logic        mstatus_mie_q, mstatus_mpie_q;
    logic        meie_q, mtie_q;
    logic [29:0] mtvec_q, mepc_q, wfi_pc_q;
    logic [31:0] mstatus_rd, mie_rd, mip_rd, mtvec_rd, mepc_rd;
    logic [31:0] old_val, new_val;
    logic [63:0] mcycle, minstret;
    logic        commit, irq, take_irq, do_mret, csr_we;
    logic        unused_bits;

    assign unused_bits = ^{ex2csr.reg_wr, ex2csr.pc[1:0]};

    always_comb begin
        mstatus_rd                 = '0;
        mstatus_rd[12:11]          = 2'b11;
        mstatus_rd[MSTATUS_MIE]    = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE]   = mstatus_mpie_q;
        mie_rd                     = '0;
        mie_rd[MIE_MEIE]           = meie_q;
        mie_rd[MIE_MTIE]           = mtie_q;
        mip_rd                     = '0;
        mip_rd[MIP_MEIP]           = meip_i;
        mip_rd[MIP_MTIP]           = mtip_i;
    end

    assign mtvec_rd = {mtvec_q, 2'b00};
    assign mepc_rd  = {mepc_q, 2'b00};

    always_comb begin
        case (ex2csr.csr_addr)
            CSR_MSTATUS:                old_val = mstatus_rd;
            CSR_MIE:                    old_val = mie_rd;
            CSR_MTVEC:                  old_val = mtvec_rd;
            CSR_MEPC:                   old_val = mepc_rd;
            CSR_MIP:                    old_val = mip_rd;
            CSR_MCYCLE,   CSR_CYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
            default:                    old_val = '0;
        endcase
    end

    assign ex2csr.rd_wdata = old_val;

    always_comb begin
        if (ex2csr.wr) begin
            new_val = ex2csr.rs1_rdata;
        end else if (ex2csr.set) begin
            new_val = old_val | ex2csr.rs1_rdata;
        end else begin
            new_val = old_val & ~ex2csr.rs1_rdata;
        end
    end

    assign irq      = (meie_q & meip_i) | (mtie_q & mtip_i);
    assign commit   = ex_valid_i & exemem_en_i;
    assign take_irq = mstatus_mie_q & irq & (commit | (state_q == SLEEP));
    assign do_mret  = commit & ex2csr.mret & ~take_irq;
    assign csr_we   = commit & ~take_irq & (ex2csr.wr | ex2csr.set | ex2csr.clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (state_q)
            RUN:   if (commit && ex2csr.wfi && !irq) state_d = SLEEP;
            SLEEP: if (irq) state_d = RUN;
        endcase
        if (take_irq) begin
            redirect_o    = 1'b1;
            redirect_pc_o = mtvec_rd;
        end else if (do_mret) begin
            redirect_o    = 1'b1;
            redirect_pc_o = mepc_rd;
        end
    end

    assign wfi_stall_o = (state_q == SLEEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            mtie_q         <= 1'b0;
            mtvec_q        <= MTVEC_RST[31:2];
            mepc_q         <= '0;
            wfi_pc_q       <= '0;
        end else begin
            if (csr_we) begin
                case (ex2csr.csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= new_val[MSTATUS_MIE];
                        mstatus_mpie_q <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        meie_q <= new_val[MIE_MEIE];
                        mtie_q <= new_val[MIE_MTIE];
                    end
                    CSR_MTVEC: mtvec_q <= new_val[31:2];
                    CSR_MEPC:  mepc_q  <= new_val[31:2];
                    default: ;
                endcase
            end
            // Leaving SLEEP resumes after the WFI, whatever EX currently holds.
            if (take_irq) begin
                mepc_q         <= (state_q == SLEEP) ? wfi_pc_q + 30'd1 : ex2csr.pc[31:2];
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (do_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
            if (state_q == RUN && state_d == SLEEP) begin
                wfi_pc_q <= ex2csr.pc[31:2];
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (1'b1),
        .wr_lo   (csr_we && ex2csr.csr_addr == CSR_MCYCLE),
        .wr_hi   (csr_we && ex2csr.csr_addr == CSR_MCYCLEH),
        .wr_data (new_val),
        .value   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (retire_i),
        .wr_lo   (csr_we && ex2csr.csr_addr == CSR_MINSTRET),
        .wr_hi   (csr_we && ex2csr.csr_addr == CSR_MINSTRETH),
        .wr_data (new_val),
        .value   (minstret)
    );

endmodule
